// File: rtl/sim_ctrl.sv
// sim_ctrl: MMIO halt/exit/signature/console/cycle window
// with a hardware signature dump engine and console FIFO.
module sim_ctrl #(
  parameter logic [31:0] BASE      = 32'h20000000,
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned CON_DEPTH = 16,
  parameter int unsigned MEM_AW    = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              store,
  input  logic              load,
  input  logic [31:0]       address,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              hit,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic              con_valid,
  input  logic              con_ready,
  output logic [7:0]        con_data,
  output logic              halted,
  output logic              done,
  output logic [30:0]       exit_code,
  output logic              pass
);

  localparam int CW = $clog2(CON_DEPTH);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT) - 32'd1;
  localparam bit TMO_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    RUN, RD, WAIT, OUT, DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_cycle;
  logic [31:0] r_sig_beg;
  logic [31:0] r_sig_end;
  logic [29:0] r_ptr;
  logic [31:0] r_dump;
  logic [31:0] r_ldata;
  logic        r_hit;
  logic        r_halted;
  logic        r_done;
  logic        r_tmo;
  logic        r_ovf;
  logic [30:0] r_exit;
  logic [7:0]  r_fifo [CON_DEPTH];
  logic [CW:0] r_wp;
  logic [CW:0] r_rp;

  logic        w_hit;
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_halt_wr;
  logic        w_tmo_ev;
  logic        w_halt_ev;
  logic [29:0] w_beg_w;
  logic [29:0] w_end_w;
  logic [29:0] w_ptr_nx;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_acc;
  logic [31:0] w_rd;

  assign w_hit     = (address[31:5] == BASE[31:5]);
  assign w_off     = address[4:2];
  assign w_wr      = store && w_hit && (address[1:0] == 2'b00)
                     && !r_halted;
  assign w_halt_wr = w_wr && (w_off == 3'd0) && store_data[0];
  assign w_tmo_ev  = (r_state == RUN) && TMO_EN
                     && (r_cycle == TMO_LAST);
  assign w_halt_ev = (r_state == RUN) && (w_halt_wr || w_tmo_ev);
  assign w_beg_w   = r_sig_beg[31:2];
  assign w_end_w   = r_sig_end[31:2];
  assign w_ptr_nx  = r_ptr + 30'd1;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[CW] != r_rp[CW])
                   && (r_wp[CW-1:0] == r_rp[CW-1:0]);
  assign w_push  = w_wr && (w_off == 3'd3);
  assign w_pop   = !w_empty && con_ready;
  assign w_acc   = w_push && (!w_full || w_pop);

  always_comb begin
    w_rd = 32'd0;
    unique case (w_off)
      3'd1:    w_rd = r_sig_beg;
      3'd2:    w_rd = r_sig_end;
      3'd4:    w_rd = r_cycle;
      3'd5:    w_rd = {27'd0, r_ovf, r_tmo, r_done, r_halted, 1'b1};
      default: w_rd = 32'd0;
    endcase
  end

  // storage needs no reset: emptiness is carried by the pointers
  always_ff @(posedge clock) begin
    if (w_acc) r_fifo[r_wp[CW-1:0]] <= store_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= RUN;
      r_cycle   <= '0;
      r_sig_beg <= '0;
      r_sig_end <= '0;
      r_ptr     <= '0;
      r_dump    <= '0;
      r_ldata   <= '0;
      r_hit     <= 1'b0;
      r_halted  <= 1'b0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
      r_ovf     <= 1'b0;
      r_exit    <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
    end else begin
      r_hit   <= (load || store) && w_hit;
      r_ldata <= (load && w_hit) ? w_rd : 32'd0;
      if (w_wr && (w_off == 3'd1)) r_sig_beg <= store_data;
      if (w_wr && (w_off == 3'd2)) r_sig_end <= store_data;
      if (w_acc) r_wp <= r_wp + {{CW{1'b0}}, 1'b1};
      if (w_pop) r_rp <= r_rp + {{CW{1'b0}}, 1'b1};
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      unique case (r_state)
        RUN: begin
          if (w_halt_ev) begin
            r_halted <= 1'b1;
            r_ptr    <= w_beg_w;
            if (w_tmo_ev) begin
              r_tmo  <= 1'b1;
              r_exit <= '1;
            end else begin
              r_exit <= store_data[31:1];
            end
            r_state <= (w_beg_w < w_end_w) ? RD : DONE;
          end else begin
            r_cycle <= r_cycle + 32'd1;
          end
        end
        RD:   r_state <= WAIT;
        WAIT: begin
          r_dump  <= mem_rdata;
          r_state <= OUT;
        end
        OUT: begin
          if (dump_ready) begin
            r_ptr   <= w_ptr_nx;
            r_state <= (w_ptr_nx < w_end_w) ? RD : DONE;
          end
        end
        DONE:    r_done <= 1'b1;
        default: r_state <= RUN;
      endcase
    end
  end

  assign load_data  = r_ldata;
  assign hit        = r_hit;
  assign mem_re     = (r_state == RD);
  assign mem_raddr  = r_ptr[MEM_AW-1:0];
  assign dump_valid = (r_state == OUT);
  assign dump_data  = r_dump;
  assign con_valid  = !w_empty;
  assign con_data   = w_empty ? 8'd0 : r_fifo[r_rp[CW-1:0]];
  assign halted     = r_halted;
  assign done       = r_done;
  assign exit_code  = r_exit;
  assign pass       = r_done && (r_exit == 31'd0) && !r_tmo;

endmodule

// File: tb/tb_sim_ctrl.sv
// tb_sim_ctrl: randomized bench for sim_ctrl against a
// transaction-level model of dumps, console and cycle count.
module tb_sim_ctrl;
  localparam logic [31:0] BASE = 32'h20000000;
  localparam int TMO = 50;

  logic        clock = 0;
  logic        reset = 1;
  logic        store = 0;
  logic        load = 0;
  logic [31:0] address = 0;
  logic [31:0] store_data = 0;
  logic [31:0] load_data;
  logic        hit;
  logic        mem_re;
  logic [29:0] mem_raddr;
  logic [31:0] mem_rdata = 0;
  logic        dump_valid;
  logic        dump_ready = 0;
  logic [31:0] dump_data;
  logic        con_valid;
  logic        con_ready = 0;
  logic [7:0]  con_data;
  logic        halted;
  logic        done;
  logic [30:0] exit_code;
  logic        pass;

  sim_ctrl #(
    .BASE(BASE), .TIMEOUT(TMO), .CON_DEPTH(16), .MEM_AW(30)
  ) u_dut (
    .clock(clock), .reset(reset), .store(store), .load(load),
    .address(address), .store_data(store_data),
    .load_data(load_data), .hit(hit),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data),
    .con_valid(con_valid), .con_ready(con_ready),
    .con_data(con_data),
    .halted(halted), .done(done), .exit_code(exit_code),
    .pass(pass)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [0:255];
  always @(posedge clock)
    if (mem_re) mem_rdata <= mem[mem_raddr[7:0]];

  int          n_re;
  logic [31:0] dq[$];
  logic [7:0]  cq[$];
  always @(posedge clock) begin
    if (!reset && mem_re) n_re++;
    if (!reset && dump_valid && dump_ready) dq.push_back(dump_data);
    if (!reset && con_valid && con_ready) cq.push_back(con_data);
  end

  logic [31:0] m_cyc;
  bit          m_halt;
  always @(posedge clock) begin
    if (reset) begin
      m_cyc  <= 0;
      m_halt <= 0;
    end else if (!m_halt) begin
      if ((store && address == BASE && store_data[0])
          || m_cyc == TMO - 1)
        m_halt <= 1;
      else
        m_cyc <= m_cyc + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1; store = 0; load = 0;
    dump_ready = 0; con_ready = 0;
    tick(2);
    reset = 0;
    dq.delete(); cq.delete(); n_re = 0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d,
                    input logic [1:0] lo = 2'b00);
    address = BASE + {27'd0, off, lo};
    store_data = d;
    store = 1;
    tick();
    store = 0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] v);
    address = BASE + {27'd0, off, 2'b00};
    load = 1;
    tick();
    load = 0;
    v = load_data;
  endtask

  task automatic wait_done(input string tag, input int bound,
                           input bit rnd);
    int k;
    for (k = 0; k < bound; k++) begin
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done) break;
    end
    if (k == bound) check({tag, "_bound"}, 0, 1);
    dump_ready = 0;
  endtask

  task automatic run_dump(input string tag, input logic [29:0] bw,
                          input int n, input logic [30:0] code,
                          input bit rnd, input bit fixed);
    logic [31:0] exp[$];
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < n; i++) begin
      v = fixed ? 32'hA + i : $urandom;
      mem[8'(bw + 30'(i))] = v;
      exp.push_back(v);
    end
    wr(3'd0, 32'h1, 2'b01);
    check({tag, "_misal"}, halted, 0);
    wr(3'd1, {bw, 2'b00});
    wr(3'd2, {bw + 30'(n), 2'b00});
    wr(3'd0, {code, 1'b1});
    check({tag, "_halted"}, halted, 1);
    wait_done(tag, 300, rnd);
    check({tag, "_nwords"}, dq.size(), n);
    check({tag, "_nre"}, n_re, n);
    for (int i = 0; i < n && i < dq.size(); i++)
      check({tag, "_word"}, dq[i], exp[i]);
    check({tag, "_exit"}, exit_code, code);
    check({tag, "_pass"}, pass, code == 0);
    rd(3'd4, v);
    check({tag, "_cycle"}, v, m_cyc);
    rd(3'd1, v);
    check({tag, "_beg"}, v, {bw, 2'b00});
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] x, y;
    logic [7:0]  b [17];
    int k;

    do_reset();
    check("rst_halted", halted, 0);
    check("rst_done", done, 0);
    check("rst_dv", dump_valid, 0);
    check("rst_cv", con_valid, 0);
    check("rst_re", mem_re, 0);
    check("rst_exit", exit_code, 0);
    check("rst_pass", pass, 0);
    check("rst_ld", load_data, 0);
    rd(3'd5, v);
    check("rst_status", v, 32'h1);
    check("rd_hit", hit, 1);
    rd(3'd6, v);
    check("rd_other", v, 0);
    address = BASE + 32; load = 1; tick(); load = 0;
    check("miss_hit", hit, 0);
    check("miss_ld", load_data, 0);

    run_dump("abc", 30'h40, 3, 31'd0, 0, 1);
    check("abc_done", done, 1);

    do_reset();
    wr(3'd0, 32'h7);
    check("c3_halted", halted, 1);
    check("c3_done0", done, 0);
    tick();
    check("c3_done1", done, 1);
    check("c3_exit", exit_code, 3);
    check("c3_pass", pass, 0);
    check("c3_nre", n_re, 0);
    wr(3'd3, 32'h55);
    wr(3'd1, 32'h40);
    tick();
    check("c3_con", con_valid, 0);
    rd(3'd1, v);
    check("c3_beg", v, 0);

    do_reset();
    x = $urandom; y = $urandom;
    mem[8'h20] = x; mem[8'h21] = y;
    wr(3'd1, 32'h80); wr(3'd2, 32'h88); wr(3'd0, 32'h1);
    for (k = 0; k < 20 && !dump_valid; k++) tick();
    check("st_valid", dump_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("st_hold_v", dump_valid, 1);
      check("st_hold_d", dump_data, x);
    end
    wait_done("st", 50, 0);
    check("st_n", dq.size(), 2);
    if (dq.size() == 2) begin
      check("st_w0", dq[0], x);
      check("st_w1", dq[1], y);
    end

    do_reset();
    for (k = 0; k < 100 && !halted; k++) tick();
    check("to_halted", halted, 1);
    wait_done("to", 10, 0);
    rd(3'd4, v);
    check("to_cycle", v, 49);
    check("to_exit", exit_code, 31'h7FFFFFFF);
    rd(3'd5, v);
    check("to_status", v, 32'hF);
    check("to_pass", pass, 0);
    check("to_nre", n_re, 0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      b[i] = 8'($urandom);
      wr(3'd3, {24'd0, b[i]});
    end
    rd(3'd5, v);
    check("con_status", v, 32'h11);
    check("con_valid", con_valid, 1);
    con_ready = 1;
    for (k = 0; k < 40 && cq.size() < 16; k++) tick();
    tick(2);
    check("con_n", cq.size(), 16);
    for (int i = 0; i < 16 && i < cq.size(); i++)
      check("con_byte", cq[i], b[i]);
    check("con_empty", con_valid, 0);
    con_ready = 0;

    do_reset();
    for (int i = 0; i < 3; i++) mem[8'h10 + i] = $urandom;
    wr(3'd1, 32'h40); wr(3'd2, 32'h4C); wr(3'd0, 32'h1);
    for (k = 0; k < 20 && !dump_valid; k++) tick();
    check("ra_valid", dump_valid, 1);
    reset = 1;
    tick();
    check("ra_dv", dump_valid, 0);
    check("ra_halted", halted, 0);
    check("ra_re", mem_re, 0);
    reset = 0;
    address = BASE + 16; load = 1; tick(); load = 0;
    check("ra_cycle", load_data, 0);
    dq.delete(); n_re = 0;
    tick(5);
    check("ra_nre", n_re, 0);
    wr(3'd1, 32'h40); wr(3'd2, 32'h4C); wr(3'd0, 32'h1);
    wait_done("ra", 50, 0);
    check("ra_n", dq.size(), 3);
    for (int i = 0; i < 3 && i < dq.size(); i++)
      check("ra_word", dq[i], mem[8'h10 + i]);

    for (int t = 0; t < 6; t++)
      run_dump("rnd", 30'($urandom_range(0, 200)),
               $urandom_range(0, 4),
               (t % 3 == 0) ? 31'd0 : 31'($urandom), 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
